divider_arbiter: RTL and testbench
==================================

Name: divider_arbiter

Overview:
- Shares the single fixed-point (16.16 signed) Divider between two requesters, port 0 (CPU MMIO) and port 1 (secondary master, e.g. DMA/GPU).
- Arbitrates round-robin and accepts each requester's operand pair with a valid/ready handshake.
- Sequences the divider's two-step protocol: write_a cycle, then start cycle, then wait for done.
- Returns the quotient and status flags to the granted requester, and guards against a hung divider with a timeout.

Parameters:
- WIDTH, 32, operand/result width (16.16 fixed point).
- TIMEOUT, 80, max cycles spent in WAIT before the operation is aborted with err.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  port 0 request; held until req0_ready
- req0_a  in  WIDTH  port 0 dividend
- req0_b  in  WIDTH  port 0 divisor
- req0_ready  out  1  one-cycle accept pulse; operands latched this cycle
- rsp0_valid  out  1  one-cycle result pulse to port 0
- rsp0_val  out  WIDTH  quotient; held until the next rsp0_valid
- rsp0_dbz  out  1  divide-by-zero flag; held with rsp0_val
- rsp0_ovf  out  1  overflow flag; held with rsp0_val
- rsp0_err  out  1  timeout flag; held with rsp0_val
- req1_valid, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_val, rsp1_dbz, rsp1_ovf, rsp1_err: identical for port 1
- div_write_a  out  1  load dividend into divider
- div_start  out  1  start division
- div_a  out  WIDTH  dividend to divider
- div_b  out  WIDTH  divisor to divider
- div_busy  in  1  divider calculating
- div_done  in  1  divider complete (one-cycle pulse)
- div_dbz  in  1  divider divide-by-zero
- div_ovf  in  1  divider overflow
- div_val  in  WIDTH  divider quotient

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; timeout counter 0.
- FSM states: IDLE -> LOAD_A -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any reqN_valid is high, grant one request. When both are high, grant the port not in last_grant.
  - Assert reqN_ready for 1 cycle, latch a, b and grant id, update last_grant, then go to LOAD_A.
  - If no request is valid, stay in IDLE.
- LOAD_A (1 cycle): div_write_a=1, div_a=latched a.
- START:
  - If div_busy=1, stay in START with div_start=0.
  - Otherwise assert div_start=1 for exactly 1 cycle with div_a=0 and div_b=latched b, clear the counter, then go to WAIT.
- WAIT:
  - div_b stays at latched b.
  - On div_done: capture div_val, div_dbz, div_ovf; set err=0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done: val=0, dbz=0, ovf=0, err=1; go to RESP.
- RESP (1 cycle): rspN_valid=1 for the granted port only, with captured fields; then go to IDLE. The other port's rsp fields are untouched.
- Outside LOAD_A, div_write_a=0. Outside START, div_start=0. div_a=0 in every state except LOAD_A.
- Latency: with ready in cycle T, write_a is in T+1 and start in T+2 (if not busy). Done in cycle D gives rsp in D+1. The next ready is at D+2 at the earliest.
- No response backpressure: the requester must sample the one-cycle rsp pulse.
- div_done outside WAIT is ignored.
- A request deasserted before ready is never accepted. Request inputs are ignored outside IDLE.
- Quotient: passed unmodified; no arithmetic is performed in this block.
- Reset mid-operation (any state): immediate return to IDLE with reset values. The in-flight operation is discarded with no rsp pulse. A stale div_done arriving after reset is ignored.

Test Plan:
1. Single op, port 0: a=0x00110000 (17.0), b=0x00030000 (3.0). Required: req0_ready 1 cycle; write_a one cycle later with div_a=0x00110000; start the next cycle with div_b=0x00030000; rsp0_valid the cycle after div_done, rsp0_val=0x0005AAAA, dbz=ovf=err=0; rsp1_valid never asserted.
2. Divide by zero, port 1: a=0x00050000, b=0. Required: rsp1_valid with rsp1_dbz=1, err=0.
3. Contention: both valid from reset. Required grant order port 0, port 1, port 0, port 1. Each response goes only to the issuing port with correct quotients (e.g. 6.0/2.0 -> 0x00030000 on port 0, 1.0/4.0 -> 0x00004000 on port 1).
4. Busy hold: divider model holds div_busy=1 for 5 cycles after write_a. Required: div_start asserted only in the first cycle div_busy=0, exactly one cycle wide.
5. Timeout: divider model never pulses done. Required: rsp0_valid exactly TIMEOUT cycles after the start cycle, rsp0_err=1, rsp0_val=0; the following request completes normally.
6. Reset mid-WAIT: assert rst 3 cycles after start, then release. Required: all outputs 0 during reset; no rsp pulse; a late div_done is ignored; the next request behaves as in scenario 1.

Source files
------------

// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one 16.16 signed fixed-point divider between two requesters.
//   Requests are arbitrated round-robin. Each granted operation runs the
//   divider's two-step protocol: a write_a cycle, a start cycle, then a wait
//   for done. The quotient and flags go back to the granted port only. A
//   divider that never reports done is abandoned after TIMEOUT cycles and the
//   port receives an err response.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   reqN_valid/_a/_b      request N with dividend and divisor, held until ready
//   reqN_ready            one-cycle accept pulse (operands latched that cycle)
//   rspN_valid            one-cycle response pulse to port N
//   rspN_val/_dbz/_ovf/_err  quotient and flags, held until the next rspN_valid
//   div_write_a, div_start   divider control strobes
//   div_a, div_b          operands presented to the divider
//   div_busy, div_done    divider status (done is a one-cycle pulse)
//   div_dbz, div_ovf, div_val  divider result, sampled on div_done
module divider_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_val,
  output logic             rsp0_dbz,
  output logic             rsp0_ovf,
  output logic             rsp0_err,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_val,
  output logic             rsp1_dbz,
  output logic             rsp1_ovf,
  output logic             rsp1_err,
  output logic             div_write_a,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_val
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic signed [WIDTH-1:0] a_q, b_q;

  logic                    pick;
  logic                    accept;
  logic                    cap_en;
  logic signed [WIDTH-1:0] cap_val;
  logic                    cap_dbz, cap_ovf, cap_err;

  logic signed [WIDTH-1:0] val0_q, val1_q;
  logic                    dbz0_q, ovf0_q, err0_q;
  logic                    dbz1_q, ovf1_q, err1_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cap_en  = 1'b0;
    cap_val = '0;
    cap_dbz = 1'b0;
    cap_ovf = 1'b0;
    cap_err = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    // On a tie the port that was not served last wins; otherwise whoever asks.
    pick    = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          accept  = 1'b1;
          gnt_d   = pick;
          last_d  = pick;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        state_d = S_START;
      end
      S_START: begin
        if (!div_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_done) begin
          cap_en  = 1'b1;
          cap_val = div_val;
          cap_dbz = div_dbz;
          cap_ovf = div_ovf;
          state_d = S_RESP;
        end else if (cnt_inc == CNT_LAST) begin
          // Divider is considered hung: report err with a zero quotient.
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      val0_q  <= '0;
      dbz0_q  <= 1'b0;
      ovf0_q  <= 1'b0;
      err0_q  <= 1'b0;
      val1_q  <= '0;
      dbz1_q  <= 1'b0;
      ovf1_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      if (cap_en && !gnt_q) begin
        val0_q <= cap_val;
        dbz0_q <= cap_dbz;
        ovf0_q <= cap_ovf;
        err0_q <= cap_err;
      end
      if (cap_en && gnt_q) begin
        val1_q <= cap_val;
        dbz1_q <= cap_dbz;
        ovf1_q <= cap_ovf;
        err1_q <= cap_err;
      end
    end
  end

  // Operand latches carry no reset: they are only observed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= pick ? req1_a : req0_a;
      b_q <= pick ? req1_b : req0_b;
    end
  end

  // Ready is gated by rst so no accept pulse can appear while reset is held.
  assign req0_ready  = accept & ~pick & ~rst;
  assign req1_ready  = accept &  pick & ~rst;

  assign div_write_a = (state_q == S_LOAD_A);
  assign div_start   = (state_q == S_START) && !div_busy;
  assign div_a       = (state_q == S_LOAD_A) ? a_q : '0;
  assign div_b       = ((state_q == S_START) || (state_q == S_WAIT)) ? b_q : '0;

  assign rsp0_valid  = (state_q == S_RESP) && !gnt_q;
  assign rsp1_valid  = (state_q == S_RESP) &&  gnt_q;
  assign rsp0_val    = val0_q;
  assign rsp0_dbz    = dbz0_q;
  assign rsp0_ovf    = ovf0_q;
  assign rsp0_err    = err0_q;
  assign rsp1_val    = val1_q;
  assign rsp1_dbz    = dbz1_q;
  assign rsp1_ovf    = ovf1_q;
  assign rsp1_err    = err1_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: directed scenarios against a cycle-level
// transaction model, with a behavioural divider on the divider-side ports.
module tb_divider_arbiter;
  localparam int W  = 32;
  localparam int TO = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_val, rsp1_val;
  logic         rsp0_dbz, rsp0_ovf, rsp0_err;
  logic         rsp1_dbz, rsp1_ovf, rsp1_err;
  logic         div_write_a, div_start;
  logic [W-1:0] div_a, div_b;
  logic         div_busy = 1'b0, div_done = 1'b0, div_dbz = 1'b0, div_ovf = 1'b0;
  logic [W-1:0] div_val = '0;

  divider_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_val(rsp0_val), .rsp0_dbz(rsp0_dbz),
    .rsp0_ovf(rsp0_ovf), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_val(rsp1_val), .rsp1_dbz(rsp1_dbz),
    .rsp1_ovf(rsp1_ovf), .rsp1_err(rsp1_err),
    .div_write_a(div_write_a), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz), .div_ovf(div_ovf),
    .div_val(div_val)
  );

  // ---------------- behavioural divider ----------------
  int           cfg_busy    = 0;
  int           cfg_delay   = 3;
  bit           cfg_no_done = 1'b0;
  int           busy_left   = 0;
  int           done_cnt    = 0;
  logic [W-1:0] env_a = '0;
  logic [W-1:0] q_val = '0;
  logic         q_dbz = 1'b0, q_ovf = 1'b0;
  logic         nb, nd;

  function automatic void div_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] v, output logic dz, output logic ov);
    longint num, q;
    if (b == '0) begin
      v = '0; dz = 1'b1; ov = 1'b0;
    end else begin
      num = longint'($signed(a)) <<< 16;
      q   = num / longint'($signed(b));
      v   = q[31:0];
      dz  = 1'b0;
      ov  = (q != longint'($signed(q[31:0])));
    end
  endfunction

  // Pending done survives reset on purpose, giving a stale done after reset.
  always begin
    @(negedge clk);
    nd = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) nd = 1'b1;
    end
    if (div_write_a) begin
      env_a = div_a;
      if (cfg_busy > 0) busy_left = cfg_busy;
    end
    if (div_start && !cfg_no_done) begin
      done_cnt = cfg_delay;
      div_model(env_a, div_b, q_val, q_dbz, q_ovf);
    end
    nb = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    @(posedge clk);
    #1;
    div_busy = nb;
    div_done = nd;
    if (nd) begin
      div_val = q_val;
      div_dbz = q_dbz;
      div_ovf = q_ovf;
    end
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  int           m_port, m_acc, m_start, m_resp;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] pend_v;
  logic         pend_d, pend_o, pend_e;
  logic [W-1:0] hv [2];
  logic         hd [2], ho [2], he [2];

  int           cyc = 0;
  int           n_rsp [2];
  int           n_start = 0;
  int           last_ready [2];
  int           last_rsp [2];
  int           last_write = 0, last_start = 0, last_done = 0;
  logic [W-1:0] cap_val [2];
  logic         cap_dbz [2], cap_ovf [2], cap_err [2];
  int           grant_q [$];
  logic [W-1:0] rsp_q0 [$];
  logic [W-1:0] rsp_q1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One call per cycle at the falling edge: derive what every output must be
  // from the transaction timeline, then compare.
  task automatic model_cycle();
    logic         e_r0, e_r1, e_w, e_s, e_bchk, e_v0, e_v1;
    logic [W-1:0] e_a, e_b;
    int           el;
    e_r0 = 1'b0; e_r1 = 1'b0; e_w = 1'b0; e_s = 1'b0; e_bchk = 1'b0;
    e_v0 = 1'b0; e_v1 = 1'b0; e_a = '0; e_b = '0;
    cyc++;

    if (req0_ready) begin last_ready[0] = cyc; grant_q.push_back(0); end
    if (req1_ready) begin last_ready[1] = cyc; grant_q.push_back(1); end
    if (div_write_a) last_write = cyc;
    if (div_start) begin last_start = cyc; n_start++; end
    if (div_done) last_done = cyc;
    if (rsp0_valid) begin
      n_rsp[0]++; last_rsp[0] = cyc; rsp_q0.push_back(rsp0_val);
      cap_val[0] = rsp0_val; cap_dbz[0] = rsp0_dbz; cap_ovf[0] = rsp0_ovf; cap_err[0] = rsp0_err;
    end
    if (rsp1_valid) begin
      n_rsp[1]++; last_rsp[1] = cyc; rsp_q1.push_back(rsp1_val);
      cap_val[1] = rsp1_val; cap_dbz[1] = rsp1_dbz; cap_ovf[1] = rsp1_ovf; cap_err[1] = rsp1_err;
    end

    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      for (int p = 0; p < 2; p++) begin
        hv[p] = '0; hd[p] = 1'b0; ho[p] = 1'b0; he[p] = 1'b0;
      end
      e_bchk = 1'b1;
    end else if (!m_busy) begin
      e_r0 = req0_valid && (!req1_valid || m_last);
      e_r1 = req1_valid && (!req0_valid || !m_last);
      if (e_r0 || e_r1) begin
        m_busy  = 1'b1;
        m_port  = e_r1 ? 1 : 0;
        m_a     = e_r1 ? req1_a : req0_a;
        m_b     = e_r1 ? req1_b : req0_b;
        m_acc   = cyc;
        m_start = -1;
        m_resp  = -1;
        m_last  = e_r1;
      end
    end else begin
      el = cyc - m_acc;
      if (el == 1) begin
        e_w = 1'b1;
        e_a = m_a;
      end else if (m_start < 0) begin
        e_bchk = 1'b1;
        e_b    = m_b;
        e_s    = !div_busy;
        if (e_s) m_start = cyc;
      end else if (m_resp < 0) begin
        e_bchk = 1'b1;
        e_b    = m_b;
        if (div_done) begin
          m_resp = cyc + 1;
          pend_v = div_val; pend_d = div_dbz; pend_o = div_ovf; pend_e = 1'b0;
        end else if (cyc - m_start == TO - 1) begin
          m_resp = cyc + 1;
          pend_v = '0; pend_d = 1'b0; pend_o = 1'b0; pend_e = 1'b1;
        end
      end else begin
        hv[m_port] = pend_v; hd[m_port] = pend_d; ho[m_port] = pend_o; he[m_port] = pend_e;
        if (m_port == 0) e_v0 = 1'b1;
        else             e_v1 = 1'b1;
        m_busy = 1'b0;
      end
    end

    chk1("req0_ready", req0_ready, e_r0);
    chk1("req1_ready", req1_ready, e_r1);
    chk1("div_write_a", div_write_a, e_w);
    chk1("div_start", div_start, e_s);
    chk("div_a", div_a, e_a);
    if (e_bchk) chk("div_b", div_b, e_b);
    chk1("rsp0_valid", rsp0_valid, e_v0);
    chk1("rsp1_valid", rsp1_valid, e_v1);
    chk("rsp0_val", rsp0_val, hv[0]);
    chk1("rsp0_dbz", rsp0_dbz, hd[0]);
    chk1("rsp0_ovf", rsp0_ovf, ho[0]);
    chk1("rsp0_err", rsp0_err, he[0]);
    chk("rsp1_val", rsp1_val, hv[1]);
    chk1("rsp1_dbz", rsp1_dbz, hd[1]);
    chk1("rsp1_ovf", rsp1_ovf, ho[1]);
    chk1("rsp1_err", rsp1_err, he[1]);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic port_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int n   = 0;
    bit got = 1'b0;
    if (p == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = (p == 0) ? req0_ready : req1_ready;
    end
    chk1($sformatf("ready%0d_seen", p), got, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_busy || req0_valid || req1_valid) && n < 400);
    chk1("idle_reached", (n < 400), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int exp_g [4] = '{0, 1, 0, 1};
    int r0, r1;
    n_rsp[0] = 0; n_rsp[1] = 0;
    last_ready[0] = 0; last_ready[1] = 0;
    last_rsp[0] = 0; last_rsp[1] = 0;

    // Contention: both requesters valid straight out of reset.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h0006_0000; req0_b = 32'h0002_0000;
    req1_valid = 1'b1; req1_a = 32'h0001_0000; req1_b = 32'h0004_0000;
    fork
      forever begin
        @(negedge clk);
        model_cycle();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      begin
        port_op(0, 32'h0006_0000, 32'h0002_0000, 1'b1);
        port_op(0, 32'h0011_0000, 32'h0003_0000, 1'b0);
      end
      begin
        port_op(1, 32'h0001_0000, 32'h0004_0000, 1'b1);
        port_op(1, 32'h0003_0000, 32'h0001_0000, 1'b0);
      end
    join
    wait_idle();
    chk("s3_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s3_grant%0d", i), grant_q[i], exp_g[i]);
    chk("s3_p0_q0", rsp_q0[0], 32'h0003_0000);
    chk("s3_p0_q1", rsp_q0[1], 32'h0005_AAAA);
    chk("s3_p1_q0", rsp_q1[0], 32'h0000_4000);
    chk("s3_p1_q1", rsp_q1[1], 32'h0003_0000);

    // Single op on port 0: 17.0 / 3.0.
    r1 = n_rsp[1];
    port_op(0, 32'h0011_0000, 32'h0003_0000, 1'b0);
    wait_idle();
    chk("s1_write_lat", last_write - last_ready[0], 1);
    chk("s1_start_lat", last_start - last_ready[0], 2);
    chk("s1_rsp_lat", last_rsp[0] - last_done, 1);
    chk("s1_val", cap_val[0], 32'h0005_AAAA);
    chk1("s1_dbz", cap_dbz[0], 1'b0);
    chk1("s1_err", cap_err[0], 1'b0);
    chk("s1_no_rsp1", n_rsp[1], r1);

    // Divide by zero on port 1.
    port_op(1, 32'h0005_0000, 32'h0000_0000, 1'b0);
    wait_idle();
    chk1("s2_dbz", cap_dbz[1], 1'b1);
    chk1("s2_err", cap_err[1], 1'b0);

    // Divider busy for 5 cycles after write_a.
    cfg_busy = 5;
    port_op(0, 32'h0001_0000, 32'h0002_0000, 1'b0);
    wait_idle();
    cfg_busy = 0;
    chk("s4_start_gap", last_start - last_write, 6);
    chk("s4_val", cap_val[0], 32'h0000_8000);

    // Hung divider.
    cfg_no_done = 1'b1;
    port_op(0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_idle();
    cfg_no_done = 1'b0;
    chk("s5_timeout_lat", last_rsp[0] - last_start, TO);
    chk1("s5_err", cap_err[0], 1'b1);
    chk("s5_val", cap_val[0], 32'h0000_0000);
    port_op(1, 32'h0009_0000, 32'h0003_0000, 1'b0);
    wait_idle();
    chk("s5_after_val", cap_val[1], 32'h0003_0000);
    chk1("s5_after_err", cap_err[1], 1'b0);

    // Reset three cycles after start; done arrives late, after reset.
    cfg_delay = 10;
    r0 = n_rsp[0];
    r1 = n_rsp[1];
    port_op(0, 32'h0011_0000, 32'h0003_0000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("s6_start_lat", last_start - last_ready[0], 2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    cfg_delay = 3;
    chk1("s6_stale_done_seen", (last_done > last_start + 3), 1'b1);
    chk("s6_no_rsp0", n_rsp[0], r0);
    chk("s6_no_rsp1", n_rsp[1], r1);
    port_op(0, 32'h0011_0000, 32'h0003_0000, 1'b0);
    wait_idle();
    chk("s6_write_lat", last_write - last_ready[0], 1);
    chk("s6_start_lat2", last_start - last_ready[0], 2);
    chk("s6_val", cap_val[0], 32'h0005_AAAA);
    chk("s6_rsp_count", n_rsp[0], r0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
